// File: rtl/uart_axi_arbiter_pkg.sv
// Shared widths, AXI response codes and sizing helper for the UART-Lite AXI arbiter.
package uart_axi_arbiter_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned AXI_AW_DEF = 32;
  localparam int unsigned RESP_W     = 2;

  localparam logic [RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEF  = 3'b000;
  localparam logic [3:0] AXI_STRB_FULL = 4'b1111;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_axi_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module uart_axi_arbiter_rr_picker
  import uart_axi_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_c_o,
  output logic [IDX_W-1:0]   idx_c_o
);

  always_comb begin
    int unsigned cand;
    any_c_o = 1'b0;
    idx_c_o = '0;
    cand    = 32'd0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_c_o && req_i[IDX_W'(cand)]) begin
        any_c_o = 1'b1;
        idx_c_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_axi_arbiter.sv
// Round-robin sequencer sharing one AXI4-Lite master port among NUM_REQ requesters,
// running exactly one complete read or write per grant.
module uart_axi_arbiter
  import uart_axi_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AXI_AW  = AXI_AW_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*AXI_AW-1:0]   req_addr_i,
  input  logic [NUM_REQ*WORD_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]          done_o,
  output logic [WORD_W-1:0]           rdata_o,
  output logic [RESP_W-1:0]           resp_o,
  output logic                        busy_o,
  output logic                        axi_awvalid_o,
  input  logic                        axi_awready_i,
  output logic [AXI_AW-1:0]           axi_awaddr_o,
  output logic [2:0]                  axi_awprot_o,
  output logic                        axi_wvalid_o,
  input  logic                        axi_wready_i,
  output logic [WORD_W-1:0]           axi_wdata_o,
  output logic [3:0]                  axi_wstrb_o,
  input  logic                        axi_bvalid_i,
  output logic                        axi_bready_o,
  input  logic [RESP_W-1:0]           axi_bresp_i,
  output logic                        axi_arvalid_o,
  input  logic                        axi_arready_i,
  output logic [AXI_AW-1:0]           axi_araddr_o,
  output logic [2:0]                  axi_arprot_o,
  input  logic                        axi_rvalid_i,
  output logic                        axi_rready_o,
  input  logic [WORD_W-1:0]           axi_rdata_i,
  input  logic [RESP_W-1:0]           axi_rresp_i
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ADDR  = 3'd1;
  localparam logic [2:0] S_RD_DATA  = 3'd2;
  localparam logic [2:0] S_WR_AW_W  = 3'd3;
  localparam logic [2:0] S_WR_RESP  = 3'd4;
  localparam logic [2:0] S_COMPLETE = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic               arvalid_q, arvalid_d, rready_q, rready_d;
  logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [AXI_AW-1:0]  araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [RESP_W-1:0]  resp_q, resp_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [AXI_AW-1:0]  sel_addr;
  logic [WORD_W-1:0]  sel_wdata;

  uart_axi_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .any_c_o (pick_any),
    .idx_c_o (pick_idx)
  );

  // Payload of the picked requester.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr  = req_addr_i[i*AXI_AW +: AXI_AW];
        sel_wdata = req_wdata_i[i*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    done_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          idx_d = pick_idx;
          if (req_we_i[pick_idx]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = sel_addr;
            wdata_d   = sel_wdata;
            state_d   = S_WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = sel_addr;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        if (axi_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (axi_rvalid_i) begin
          rready_d      = 1'b0;
          rdata_d       = axi_rdata_i;
          resp_d        = axi_rresp_i;
          done_d[idx_q] = 1'b1;
          state_d       = S_COMPLETE;
        end
      end
      S_WR_AW_W: begin
        // AW and W retire independently; move on once neither is still pending.
        if (axi_awready_i) awvalid_d = 1'b0;
        if (axi_wready_i)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (axi_bvalid_i) begin
          bready_d      = 1'b0;
          resp_d        = axi_bresp_i;
          done_d[idx_q] = 1'b1;
          state_d       = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        // req is deliberately not sampled here so a dropping requester is not regranted.
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= AXI_RESP_OKAY;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign done_o        = done_q;
  assign rdata_o       = rdata_q;
  assign resp_o        = resp_q;
  assign busy_o        = busy_q;
  assign axi_arvalid_o = arvalid_q;
  assign axi_araddr_o  = araddr_q;
  assign axi_arprot_o  = AXI_PROT_DEF;
  assign axi_rready_o  = rready_q;
  assign axi_awvalid_o = awvalid_q;
  assign axi_awaddr_o  = awaddr_q;
  assign axi_awprot_o  = AXI_PROT_DEF;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = AXI_STRB_FULL;
  assign axi_bready_o  = bready_q;

endmodule

// File: tb/tb_uart_axi_arbiter.sv
// Directed bench for uart_axi_arbiter: delay-programmable AXI-Lite slave, transaction-level model.
module tb_uart_axi_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req = '0, req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N-1:0]    done_o;
  logic [31:0]     rdata_o;
  logic [1:0]      resp_o;
  logic            busy_o;
  logic            awvalid, awready = 1'b1, wvalid, wready = 1'b1, bvalid = 1'b0, bready;
  logic            arvalid, arready = 1'b1, rvalid = 1'b0, rready;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic [31:0]     wdata, rdata_in = '0;
  logic [3:0]      wstrb;
  logic [1:0]      bresp = 2'b00, rresp = 2'b00;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_axi_arbiter #(.NUM_REQ(N), .AXI_AW(AW)) dut (
    .clk(clk), .rstn(rstn), .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .done_o(done_o), .rdata_o(rdata_o), .resp_o(resp_o),
    .busy_o(busy_o), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_awaddr_o(awaddr), .axi_awprot_o(awprot), .axi_wvalid_o(wvalid),
    .axi_wready_i(wready), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb),
    .axi_bvalid_i(bvalid), .axi_bready_o(bready), .axi_bresp_i(bresp),
    .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_araddr_o(araddr),
    .axi_arprot_o(arprot), .axi_rvalid_i(rvalid), .axi_rready_o(rready),
    .axi_rdata_i(rdata_in), .axi_rresp_i(rresp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: readies come up after N cycles of valid; responses N cycles after acceptance.
  int s_ar_dly = 0, s_r_dly = 0, s_aw_dly = 0, s_w_dly = 0, s_b_dly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0, s_bresp = '0;
  int  ar_wait = 0, aw_wait = 0, w_wait = 0, r_cnt = 0, b_cnt = 0;
  bit  r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
  bit  n_arready, n_awready, n_wready, n_rvalid, n_bvalid;

  always @(posedge clk) begin
    if (!rstn) begin
      ar_wait = 0; aw_wait = 0; w_wait = 0; r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      #1;
      arready = (s_ar_dly == 0); awready = (s_aw_dly == 0); wready = (s_w_dly == 0);
      rvalid = 1'b0; bvalid = 1'b0;
    end else begin
      n_arready = arready; n_awready = awready; n_wready = wready;
      n_rvalid = rvalid; n_bvalid = bvalid;
      if (arvalid && arready) begin
        ar_wait = 0; n_arready = (s_ar_dly == 0); r_pend = 1; r_cnt = s_r_dly;
      end else if (arvalid) begin
        ar_wait++; n_arready = (ar_wait >= s_ar_dly);
      end else begin
        ar_wait = 0; n_arready = (s_ar_dly == 0);
      end
      if (awvalid && awready) begin
        aw_wait = 0; n_awready = (s_aw_dly == 0); aw_got = 1;
      end else if (awvalid) begin
        aw_wait++; n_awready = (aw_wait >= s_aw_dly);
      end else begin
        aw_wait = 0; n_awready = (s_aw_dly == 0);
      end
      if (wvalid && wready) begin
        w_wait = 0; n_wready = (s_w_dly == 0); w_got = 1;
      end else if (wvalid) begin
        w_wait++; n_wready = (w_wait >= s_w_dly);
      end else begin
        w_wait = 0; n_wready = (s_w_dly == 0);
      end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = s_b_dly;
      end
      if (rvalid && rready) n_rvalid = 1'b0;
      if (bvalid && bready) n_bvalid = 1'b0;
      if (r_pend) begin
        if (r_cnt == 0) begin n_rvalid = 1'b1; r_pend = 0; end else r_cnt--;
      end
      if (b_pend) begin
        if (b_cnt == 0) begin n_bvalid = 1'b1; b_pend = 0; end else b_cnt--;
      end
      #1;
      arready = n_arready; awready = n_awready; wready = n_wready;
      rvalid = n_rvalid; bvalid = n_bvalid;
      rdata_in = s_rdata; rresp = s_rresp; bresp = s_bresp;
    end
  end

  // Transaction-level model: phase 0 idle, 1 transfer in flight, 2 completion cycle.
  int m_phase = 0, m_idx = 0, m_ptr = 0;
  bit m_we = 0, m_first = 0, m_ar_ok = 0, m_aw_ok = 0, m_w_ok = 0;
  bit hold_ar = 0, hold_aw = 0, hold_w = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_wdata = '0, m_rdata = '0;
  logic [1:0]    m_resp = '0;
  logic [N-1:0]  exp_done = '0;

  always @(posedge clk) begin
    hold_ar = rstn && arvalid && !arready;
    hold_aw = rstn && awvalid && !awready;
    hold_w  = rstn && wvalid && !wready;
    m_first = 0;
    if (!rstn) begin
      m_phase = 0; m_ptr = 0; m_rdata = '0; m_resp = '0; exp_done = '0;
    end else begin
      case (m_phase)
        0: if (req != '0) begin
             for (int k = N - 1; k >= 0; k--)
               if (req[(m_ptr + k) % N]) m_idx = (m_ptr + k) % N;
             m_we = req_we[m_idx];
             m_addr = req_addr[m_idx*AW +: AW];
             m_wdata = req_wdata[m_idx*32 +: 32];
             m_phase = 1; m_first = 1; m_ar_ok = 0; m_aw_ok = 0; m_w_ok = 0;
           end
        1: begin
             if (arvalid && arready) m_ar_ok = 1;
             if (awvalid && awready) m_aw_ok = 1;
             if (wvalid && wready)   m_w_ok = 1;
             if (!m_we && rvalid && rready) begin
               m_rdata = rdata_in; m_resp = rresp;
               exp_done = '0; exp_done[m_idx] = 1'b1; m_phase = 2;
             end
             if (m_we && bvalid && bready) begin
               m_resp = bresp;
               exp_done = '0; exp_done[m_idx] = 1'b1; m_phase = 2;
             end
           end
        default: begin
          exp_done = '0; m_ptr = (m_idx + 1) % N; m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("done", done_o, exp_done);
      check("rdata", rdata_o, m_rdata);
      check("resp", resp_o, m_resp);
      check("busy", busy_o, m_phase != 0);
      check("ar_aw_exclusive", arvalid && awvalid, 1'b0);
      check("consts", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'b1111});
      if (hold_ar) check("arvalid_held", arvalid, 1'b1);
      if (hold_aw) check("awvalid_held", awvalid, 1'b1);
      if (hold_w)  check("wvalid_held", wvalid, 1'b1);
      if (m_phase != 1)
        check("quiet_outside_xfer", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
      if (m_first) begin
        check("first_valids", {arvalid, awvalid, wvalid}, {!m_we, m_we, m_we});
        if (m_we) check("first_aw_w", {awaddr, wdata}, {m_addr, m_wdata});
        else      check("first_araddr", araddr, m_addr);
      end
      if (m_phase == 1 && !m_we) begin
        check("rd_no_write_side", {awvalid, wvalid, bready}, 3'b0);
        check("rready_after_ar", rready && !m_ar_ok, 1'b0);
        check("arvalid_dropped", arvalid && m_ar_ok, 1'b0);
      end
      if (m_phase == 1 && m_we) begin
        check("wr_no_read_side", {arvalid, rready}, 2'b0);
        check("bready_after_aw_w", bready && !(m_aw_ok && m_w_ok), 1'b0);
        check("awvalid_dropped", awvalid && m_aw_ok, 1'b0);
        check("wvalid_dropped", wvalid && m_w_ok, 1'b0);
      end
    end
  end

  task automatic set_req(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    req_we[i] = we;
    req_addr[i*AW +: AW] = addr;
    req_wdata[i*32 +: 32] = wd;
  endtask

  task automatic wait_done(output logic [N-1:0] d, output int cyc, output int nb);
    d = '0; cyc = 0; nb = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (bready) nb++;
      if (done_o != '0) begin d = done_o; break; end
    end
    check("done_seen", d != '0, 1'b1);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rst_outputs", {done_o, busy_o, arvalid, awvalid, wvalid, rready, bready}, '0);
    check("rst_data", {rdata_o, resp_o, araddr, awaddr, wdata}, '0);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] d;
    int cyc, nb;
    logic [N-1:0] order [4];
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;

    @(posedge clk); #1;
    chk_en = 1'b1;
    apply_reset();

    // 1: single read, arready after one cycle, rvalid two cycles after AR
    s_ar_dly = 1; s_r_dly = 2; s_rdata = 32'h5; s_rresp = 2'b00;
    set_req(0, 1'b0, 32'h8, 32'h0); req = 2'b01;
    wait_done(d, cyc, nb);
    req = 2'b00;
    check("t1_done", d, 2'b01);
    check("t1_rdata", rdata_o, 32'h5);
    check("t1_resp", resp_o, 2'b00);
    check("t1_araddr", araddr, 32'h8);
    @(posedge clk); #1;
    check("t1_done_one_cycle", done_o, 2'b00);

    // 2: both request reads continuously, zero-wait slave
    apply_reset();
    s_ar_dly = 0; s_r_dly = 0; s_rdata = 32'hA5;
    set_req(0, 1'b0, 32'h10, 32'h0); set_req(1, 1'b0, 32'h14, 32'h0);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(d, cyc, nb);
      check("t2_grant_order", d, order[k]);
    end
    req = 2'b00;

    // 3: write with W accepted two cycles before AW
    s_aw_dly = 2; s_w_dly = 0; s_b_dly = 0; s_bresp = 2'b00;
    set_req(1, 1'b1, 32'h4, 32'h41); req = 2'b10;
    wait_done(d, cyc, nb);
    req = 2'b00;
    check("t3_done", d, 2'b10);
    check("t3_resp", resp_o, 2'b00);
    check("t3_aw_w", {awaddr, wdata}, {32'h4, 32'h41});
    check("t3_rdata_kept", rdata_o, 32'hA5);
    check("t3_bready_cycles", nb, 1);

    // 4: joint AW/W handshake, bvalid right after
    s_aw_dly = 0; s_w_dly = 0; s_b_dly = 0;
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'hC, 32'h1234); req = 2'b01;
    wait_done(d, cyc, nb);
    req = 2'b00;
    check("t4_done", d, 2'b01);
    check("t4_latency_edges", cyc, 3);
    check("t4_wr_resp_cycles", nb, 1);

    // 5: reset while waiting for read data, then fairness restarts at requester 0
    s_r_dly = 6;
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h20, 32'h0); req = 2'b01;
    for (int c = 0; c < 20; c++) begin
      if (rready) break;
      @(posedge clk); #1;
    end
    check("t5_reached_rd_data", rready, 1'b1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("t5_abort", {rready, arvalid, done_o, busy_o}, '0);
    rstn = 1'b1;
    s_r_dly = 0;
    set_req(1, 1'b0, 32'h24, 32'h0); req = 2'b11;
    wait_done(d, cyc, nb);
    check("t5_first_grant", d, 2'b01);
    wait_done(d, cyc, nb);
    check("t5_second_grant", d, 2'b10);
    req = 2'b00;

    // 6: error responses forwarded, later transactions still served
    s_rresp = 2'b10; s_rdata = 32'hDEAD;
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h8, 32'h0); req = 2'b10;
    wait_done(d, cyc, nb);
    req = 2'b00;
    check("t6_err_done", d, 2'b10);
    check("t6_err_resp", resp_o, 2'b10);
    s_rresp = 2'b00; s_rdata = 32'h77;
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0, 32'h0); req = 2'b01;
    wait_done(d, cyc, nb);
    req = 2'b00;
    check("t6_next_done", d, 2'b01);
    check("t6_next", {rdata_o, resp_o}, {32'h77, 2'b00});
    s_bresp = 2'b11;
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'hC, 32'h99); req = 2'b10;
    wait_done(d, cyc, nb);
    req = 2'b00;
    check("t6_decerr", {rdata_o, resp_o}, {32'h77, 2'b11});

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
